cp0_regs: RTL and testbench
===========================

Name: cp0_regs

Overview:
- Coprocessor-0 register file and exception/interrupt state holder.
- It is the responder side of the write-back stage's CP0 interface.
- It accepts exception commits, eret flushes and mtc0 writes from WB.
- It serves mfc0 reads and drives EPC/Status/Cause plus an interrupt request back to the pipeline.
- Implemented registers: BadVAddr, Count, Compare, Status, Cause, EPC.
- The 8-bit CP0 address is {rd[4:0], sel[2:0]}.

Parameters:
- CNT_DIV, 2: Count increments once every CNT_DIV clock cycles (legal values 1 or 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- wb_ex  in  1  exception committed in WB this cycle; already qualified by WB valid.
- wb_bd  in  1  excepting instruction sits in a branch delay slot.
- wb_excode  in  5  exception code.
- wb_pc  in  32  PC of the excepting instruction.
- wb_badvaddr  in  32  faulting address, used for AdEL/AdES.
- eret_flush  in  1  eret committed in WB; already qualified by WB valid.
- ext_int_in  in  6  external hardware interrupt lines, level sensitive.
- cp0_addr  in  8  read/write address: {rd, sel}.
- mtc0_we  in  1  mtc0 write enable.
- cp0_wdata  in  32  mtc0 write data.
- cp0_rdata  out  32  combinational read data for cp0_addr.
- cp0_epc  out  32  current EPC.
- cp0_status  out  32  current Status.
- cp0_cause  out  32  current Cause.
- int_req  out  1  interrupt pending; to be taken by the pipeline as an exception.

Behaviour:
- Addresses:
  - BadVAddr = 8'h40 (rd 8)
  - Count = 8'h48 (rd 9)
  - Compare = 8'h58 (rd 11)
  - Status = 8'h60 (rd 12)
  - Cause = 8'h68 (rd 13)
  - EPC = 8'h70 (rd 14)
  - Any other address: reads 0, writes ignored.
- Reset (asynchronous, all state):
  - Status = 32'h0040_0000 (BEV=1).
  - Cause, EPC, BadVAddr, Count and Compare = 0.
  - Divider tick = 0.
  - Resulting outputs: int_req = 0, cp0_epc = 0, cp0_cause = 0, cp0_status = 32'h0040_0000.
- Reads: combinational, no latency. An mtc0 write becomes visible on the next cycle; no write-through bypass.
- Status fields:
  - Bit 22 BEV is read-only 1.
  - Bits [15:8] IM are read/write.
  - Bit 1 EXL is read/write.
  - Bit 0 IE is read/write.
  - All other bits read 0.
- Cause fields:
  - Bit 31 BD is read-only, written on exception.
  - Bit 30 TI is read-only.
  - Bits [15:10] IP[7:2] are read-only, hardware-sampled.
  - Bits [9:8] IP[1:0] are read/write (software interrupts).
  - Bits [6:2] ExcCode are written on exception.
  - All other bits read 0.
- Hardware interrupt sampling, every cycle: IP[7] <= ext_int_in[5] | TI; IP[6:2] <= ext_int_in[4:0].
- Exception commit (wb_ex=1):
  - EXL <= 1.
  - ExcCode <= wb_excode.
  - If the old EXL was 0: BD <= wb_bd and EPC <= wb_bd ? wb_pc-4 : wb_pc.
  - If the old EXL was 1: EPC and BD hold.
  - If wb_excode is 5'h04 or 5'h05: BadVAddr <= wb_badvaddr.
- eret_flush: EXL <= 0.
- Same-cycle priority:
  - wb_ex beats eret_flush and beats mtc0 writes to Status, Cause and EPC; the mtc0 write is dropped.
  - eret_flush beats an mtc0 write to Status.EXL.
- Count:
  - Divider tick toggles every cycle when CNT_DIV=2, is constantly 1 when CNT_DIV=1.
  - Count <= Count+1 when tick=1, wrapping 32'hFFFF_FFFF to 0.
  - An mtc0 to Count loads cp0_wdata and overrides the increment.
- Compare / TI:
  - An mtc0 to Compare loads cp0_wdata and clears TI.
  - Otherwise TI <= 1 when Count == Compare (registered values).
  - TI is sticky until the next Compare write. Compare write wins over a simultaneous match.
- int_req = |(Cause.IP[7:0] & Status.IM[7:0]) & Status.IE & ~Status.EXL, combinational from registered state.
- Outputs cp0_epc, cp0_status and cp0_cause always reflect the registered values.

Test Plan:
- Reset: assert reset mid-run with Count=5 and EXL=1 -> immediately Count=0, cp0_status=32'h0040_0000, int_req=0, with no clock edge needed.
- Exception with BD=1: wb_ex=1, wb_bd=1, wb_pc=32'hBFC0_0104, wb_excode=5'h08 -> next cycle EPC=32'hBFC0_0100, Cause=32'h8000_0020, EXL=1. A second wb_ex with pc 32'h100 leaves EPC unchanged.
- AdEL and eret: wb_ex=1, excode=5'h04, badvaddr=32'h0000_0003 -> BadVAddr=3. Then eret_flush=1 -> EXL=0. eret_flush concurrent with mtc0 Status=32'h0000_0003 -> EXL=0, IE=1.
- Timer: mtc0 Compare=10, Count=0, CNT_DIV=2 -> TI=1 about 20 cycles later. With IM[7]=1 and IE=1, int_req=1 one cycle after TI. An mtc0 to Compare clears TI, and int_req drops on the following cycle.
- Software interrupt: mtc0 Cause=32'h0000_0100, Status=32'h0000_0101 -> int_req=1. A simultaneous wb_ex with an mtc0 to EPC=32'h1234 -> the EPC write is dropped and EPC comes from wb_pc.
- Count wrap / unmapped address: mtc0 Count=32'hFFFF_FFFF -> rolls to 0 on the next tick. A read of address 8'h78 returns 0, and a write to it changes no register.

Source files
------------

// File: rtl/cp0_regs_if.sv
// WB-stage <-> CP0 interface: exception/eret/mtc0 requests in, read data
// and exception-state outputs back to the pipeline.
interface cp0_regs_if;
    logic        wb_ex;
    logic        wb_bd;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        eret_flush;
    logic [5:0]  ext_int_in;
    logic [7:0]  cp0_addr;
    logic        mtc0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        int_req;

    modport master (
        output wb_ex, wb_bd, wb_excode, wb_pc, wb_badvaddr, eret_flush,
               ext_int_in, cp0_addr, mtc0_we, cp0_wdata,
        input  cp0_rdata, cp0_epc, cp0_status, cp0_cause, int_req
    );

    modport slave (
        input  wb_ex, wb_bd, wb_excode, wb_pc, wb_badvaddr, eret_flush,
               ext_int_in, cp0_addr, mtc0_we, cp0_wdata,
        output cp0_rdata, cp0_epc, cp0_status, cp0_cause, int_req
    );
endinterface

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC,
// plus exception/eret state tracking and interrupt request generation.
module cp0_regs #(
    parameter int CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    cp0_regs_if.slave   bus
);
    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [7:2]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exccode;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick_q;
    logic        tick;

    logic [31:0] status_word;
    logic [31:0] cause_word;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        wr_count;
    logic        wr_compare;

    // An exception commit in the same cycle drops mtc0 writes to Status/Cause/EPC.
    assign wr_status  = bus.mtc0_we && (bus.cp0_addr == ADDR_STATUS) && !bus.wb_ex;
    assign wr_cause   = bus.mtc0_we && (bus.cp0_addr == ADDR_CAUSE)  && !bus.wb_ex;
    assign wr_epc     = bus.mtc0_we && (bus.cp0_addr == ADDR_EPC)    && !bus.wb_ex;
    assign wr_count   = bus.mtc0_we && (bus.cp0_addr == ADDR_COUNT);
    assign wr_compare = bus.mtc0_we && (bus.cp0_addr == ADDR_COMPARE);

    assign tick = (CNT_DIV == 1) ? 1'b1 : tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_im  <= 8'h00;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (bus.wb_ex) begin
            status_exl <= 1'b1;
        end else if (wr_status) begin
            status_im  <= bus.cp0_wdata[15:8];
            status_ie  <= bus.cp0_wdata[0];
            status_exl <= bus.eret_flush ? 1'b0 : bus.cp0_wdata[1];
        end else if (bus.eret_flush) begin
            status_exl <= 1'b0;
        end
    end

    // BD and EPC only capture the first exception; nested ones keep the original return point.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_bd      <= 1'b0;
            cause_ip_hw   <= 6'h00;
            cause_ip_sw   <= 2'b00;
            cause_exccode <= 5'h00;
            epc           <= 32'h0;
            badvaddr      <= 32'h0;
        end else begin
            cause_ip_hw <= {bus.ext_int_in[5] | cause_ti, bus.ext_int_in[4:0]};
            if (bus.wb_ex) begin
                cause_exccode <= bus.wb_excode;
                if (!status_exl) begin
                    cause_bd <= bus.wb_bd;
                    epc      <= bus.wb_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
                end
                if (bus.wb_excode == 5'h04 || bus.wb_excode == 5'h05)
                    badvaddr <= bus.wb_badvaddr;
            end else begin
                if (wr_cause)
                    cause_ip_sw <= bus.cp0_wdata[9:8];
                if (wr_epc)
                    epc <= bus.cp0_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q   <= 1'b0;
            count    <= 32'h0;
            compare  <= 32'h0;
            cause_ti <= 1'b0;
        end else begin
            tick_q <= (CNT_DIV == 1) ? 1'b1 : ~tick_q;
            if (wr_count)
                count <= bus.cp0_wdata;
            else if (tick)
                count <= count + 32'd1;
            if (wr_compare) begin
                compare  <= bus.cp0_wdata;
                cause_ti <= 1'b0;
            end else if (count == compare) begin
                cause_ti <= 1'b1;
            end
        end
    end

    assign status_word = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_word  = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw,
                          1'b0, cause_exccode, 2'b00};

    always_comb begin
        bus.cp0_rdata = 32'h0;
        case (bus.cp0_addr)
            ADDR_BADVADDR: bus.cp0_rdata = badvaddr;
            ADDR_COUNT:    bus.cp0_rdata = count;
            ADDR_COMPARE:  bus.cp0_rdata = compare;
            ADDR_STATUS:   bus.cp0_rdata = status_word;
            ADDR_CAUSE:    bus.cp0_rdata = cause_word;
            ADDR_EPC:      bus.cp0_rdata = epc;
            default:       bus.cp0_rdata = 32'h0;
        endcase
    end

    assign bus.cp0_epc    = epc;
    assign bus.cp0_status = status_word;
    assign bus.cp0_cause  = cause_word;
    assign bus.int_req    = (|({cause_ip_hw, cause_ip_sw} & status_im))
                            & status_ie & ~status_exl;
endmodule

// File: tb/tb_cp0_regs.sv
// Self-checking bench for cp0_regs: table of mtc0/read vectors plus directed
// sequences for exceptions, eret, interrupts, timer, Count wrap and reset.
module tb_cp0_regs;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    cp0_regs_if bus();

    cp0_regs #(.CNT_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_int;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // One clock cycle of stimulus driven at negedge; strobes are cleared just after the edge.
    task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic ex, input logic bd, input logic [4:0] code,
                                 input logic [31:0] pc, input logic [31:0] bva, input logic eret);
        @(negedge clk);
        bus.mtc0_we     = we;
        bus.cp0_addr    = addr;
        bus.cp0_wdata   = wdata;
        bus.wb_ex       = ex;
        bus.wb_bd       = bd;
        bus.wb_excode   = code;
        bus.wb_pc       = pc;
        bus.wb_badvaddr = bva;
        bus.eret_flush  = eret;
        @(posedge clk);
        #1;
        bus.mtc0_we    = 1'b0;
        bus.wb_ex      = 1'b0;
        bus.eret_flush = 1'b0;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, addr, wdata, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic readReg(input logic [7:0] addr, output logic [31:0] data);
        bus.cp0_addr = addr;
        #1;
        data = bus.cp0_rdata;
    endtask

    initial begin
        logic [31:0] rd;
        logic        found;
        int          ti_cycles;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.wb_ex = 1'b0;  bus.wb_bd = 1'b0;  bus.wb_excode = 5'h0;
        bus.wb_pc = 32'h0; bus.wb_badvaddr = 32'h0; bus.eret_flush = 1'b0;
        bus.ext_int_in = 6'h0; bus.cp0_addr = 8'h0; bus.mtc0_we = 1'b0;
        bus.cp0_wdata = 32'h0;

        vecs[0] = '{1'b1, 8'h60, 32'hFFFF_FFFF, 32'h0040_FF03, 1'b0};
        vecs[1] = '{1'b1, 8'h60, 32'h0000_0000, 32'h0040_0000, 1'b0};
        vecs[2] = '{1'b1, 8'h68, 32'hFFFF_FFFF, 32'h0000_0300, 1'b0};
        vecs[3] = '{1'b1, 8'h68, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b1, 8'h70, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b1, 8'h58, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[6] = '{1'b1, 8'h78, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[7] = '{1'b1, 8'h48, 32'h0000_1000, 32'h0000_1000, 1'b0};
        vecs[8] = '{1'b0, 8'h40, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        #2;
        checkOutput("reset_status", bus.cp0_status, 32'h0040_0000);
        checkOutput("reset_cause", bus.cp0_cause, 32'h0);
        checkOutput("reset_epc", bus.cp0_epc, 32'h0);
        checkOutput("reset_int_req", {31'b0, bus.int_req}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Count==Compare at reset sets TI; move Compare away and let IP[7] settle.
        mtc0(8'h58, 32'h8000_0000);
        idleCycle();
        idleCycle();
        checkOutput("init_cause_clear", bus.cp0_cause, 32'h0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b0);
            readReg(vecs[i].addr, rd);
            checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_int_req", i), {31'b0, bus.int_req},
                        {31'b0, vecs[i].exp_int});
        end
        checkOutput("unmapped_keeps_epc", bus.cp0_epc, 32'hDEAD_BEEF);
        checkOutput("unmapped_keeps_status", bus.cp0_status, 32'h0040_0000);

        applyStimulus(1'b0, 8'h0, 32'h0, 1'b1, 1'b1, 5'h08, 32'hBFC0_0104, 32'h0, 1'b0);
        checkOutput("ex_bd_epc", bus.cp0_epc, 32'hBFC0_0100);
        checkOutput("ex_bd_cause", bus.cp0_cause, 32'h8000_0020);
        checkOutput("ex_bd_status", bus.cp0_status, 32'h0040_0002);
        applyStimulus(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 5'h08, 32'h0000_0100, 32'h0, 1'b0);
        checkOutput("nested_ex_epc", bus.cp0_epc, 32'hBFC0_0100);
        checkOutput("nested_ex_cause", bus.cp0_cause, 32'h8000_0020);

        applyStimulus(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 5'h04, 32'h0000_0200, 32'h0000_0003, 1'b0);
        readReg(8'h40, rd);
        checkOutput("adel_badvaddr", rd, 32'h0000_0003);
        checkOutput("adel_cause", bus.cp0_cause, 32'h8000_0010);
        applyStimulus(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("eret_status", bus.cp0_status, 32'h0040_0000);
        applyStimulus(1'b1, 8'h60, 32'h0000_0003, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("eret_vs_mtc0_status", bus.cp0_status, 32'h0040_0001);
        applyStimulus(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 5'h00, 32'h0000_0200, 32'h0, 1'b1);
        checkOutput("ex_vs_eret_status", bus.cp0_status, 32'h0040_0003);
        checkOutput("ex_vs_eret_epc", bus.cp0_epc, 32'h0000_0200);
        checkOutput("ex_vs_eret_cause", bus.cp0_cause, 32'h0);
        applyStimulus(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);

        mtc0(8'h68, 32'h0000_0100);
        checkOutput("swint_im_off", {31'b0, bus.int_req}, 32'h0);
        mtc0(8'h60, 32'h0000_0101);
        checkOutput("swint_req", {31'b0, bus.int_req}, 32'h1);
        applyStimulus(1'b1, 8'h70, 32'h0000_1234, 1'b1, 1'b0, 5'h00, 32'h0000_0300, 32'h0, 1'b0);
        checkOutput("ex_drops_mtc0_epc", bus.cp0_epc, 32'h0000_0300);
        checkOutput("ex_masks_int", {31'b0, bus.int_req}, 32'h0);
        applyStimulus(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("eret_unmasks_int", {31'b0, bus.int_req}, 32'h1);
        mtc0(8'h68, 32'h0);
        checkOutput("swint_cleared", {31'b0, bus.int_req}, 32'h0);

        mtc0(8'h60, 32'h0000_8001);
        mtc0(8'h58, 32'd10);
        mtc0(8'h48, 32'd0);
        found = 1'b0;
        ti_cycles = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.cp0_cause[30]) begin
                found = 1'b1;
                ti_cycles = i;
            end
        end
        checkOutput("ti_latency_in_range", {31'b0, (ti_cycles >= 19 && ti_cycles <= 22)}, 32'h1);
        checkOutput("ti_int_not_yet", {31'b0, bus.int_req}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("ti_int_req", {31'b0, bus.int_req}, 32'h1);
        checkOutput("ti_sticky", {31'b0, bus.cp0_cause[30]}, 32'h1);
        mtc0(8'h58, 32'h8000_0000);
        checkOutput("compare_clears_ti", {31'b0, bus.cp0_cause[30]}, 32'h0);
        checkOutput("int_req_lags_ti", {31'b0, bus.int_req}, 32'h1);
        idleCycle();
        checkOutput("int_req_dropped", {31'b0, bus.int_req}, 32'h0);

        mtc0(8'h48, 32'hFFFF_FFFF);
        readReg(8'h48, rd);
        checkOutput("count_loaded", rd, 32'hFFFF_FFFF);
        for (int i = 0; i < 3 && rd == 32'hFFFF_FFFF; i++) begin
            @(posedge clk);
            #1;
            rd = bus.cp0_rdata;
        end
        checkOutput("count_wrap", rd, 32'h0);

        // Count write coincides with an exception so both Count=5 and EXL=1 are set before reset.
        applyStimulus(1'b1, 8'h48, 32'd5, 1'b1, 1'b0, 5'h00, 32'h0000_0400, 32'h0, 1'b0);
        readReg(8'h48, rd);
        checkOutput("pre_reset_count", rd, 32'd5);
        checkOutput("pre_reset_status", bus.cp0_status, 32'h0040_8003);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_count", bus.cp0_rdata, 32'h0);
        checkOutput("async_reset_status", bus.cp0_status, 32'h0040_0000);
        checkOutput("async_reset_epc", bus.cp0_epc, 32'h0);
        checkOutput("async_reset_int_req", {31'b0, bus.int_req}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
